// File: rtl/tim_cnt.sv
`default_nettype none
// ============================================================================
// Module      : tim_cnt
// Description : Auto-reload up-counter timer clocked by prescaler ticks, with
//               sticky update flag and optional compare/PWM (macro TIM_CMP_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tim_cnt #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clk_pre,
   input  logic             en,
   input  logic             one_shot,
   input  logic [WIDTH-1:0] arr,
   input  logic [WIDTH-1:0] ccr,
   input  logic             irq_clr,
   output logic [WIDTH-1:0] cnt,
   output logic             running,
   output logic             upd_irq,
   output logic             cc_irq,
   output logic             cc_out
);

   localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_cnt;
   logic             r_clk_pre_q;
   logic             r_upd_irq;
   logic             w_tick;

   assign w_tick  = clk_pre & ~r_clk_pre_q;
   assign cnt     = r_cnt;
   assign running = (r_state == RUN);
   assign upd_irq = r_upd_irq;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_clk_pre_q <= 1'b0;
         r_upd_irq   <= 1'b0;
      end else begin
         r_clk_pre_q <= clk_pre;
         // Clear first so that a same-cycle set below takes precedence.
         if (irq_clr) begin
            r_upd_irq <= 1'b0;
         end
         case (r_state)
            IDLE: begin
               r_cnt <= '0;
               if (en) begin
                  r_state <= RUN;
               end
            end
            RUN: begin
               if (!en) begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
               end else if (w_tick) begin
                  if (r_cnt >= arr) begin
                     r_cnt     <= '0;
                     r_upd_irq <= 1'b1;
                     if (one_shot) begin
                        r_state <= DONE;
                     end
                  end else begin
                     r_cnt <= r_cnt + c_one;
                  end
               end
            end
            DONE: begin
               r_cnt <= '0;
               if (!en) begin
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

`ifdef TIM_CMP_EN
   logic r_cc_irq;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cc_irq <= 1'b0;
      end else if ((r_state == RUN) && en && w_tick && (r_cnt == ccr)) begin
         r_cc_irq <= 1'b1;
      end else if (irq_clr) begin
         r_cc_irq <= 1'b0;
      end
   end

   assign cc_irq = r_cc_irq;
   assign cc_out = running && (r_cnt < ccr);
`else
   logic w_unused_ccr;

   assign w_unused_ccr = ^ccr;
   assign cc_irq       = 1'b0;
   assign cc_out       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tim_cnt.sv
`default_nettype none
// ============================================================================
// Module      : tb_tim_cnt
// Description : Self-checking bench for tim_cnt: vector table, directed
//               corner sequences and randomized run against a timer model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tim_cnt;

   localparam int W = 8;
`ifdef TIM_CMP_EN
   localparam bit CMP = 1'b1;
`else
   localparam bit CMP = 1'b0;
`endif

   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_DONE = 2;

   logic         clk = 1'b0;
   logic         rst;
   logic         clk_pre;
   logic         en;
   logic         one_shot;
   logic [W-1:0] arr;
   logic [W-1:0] ccr;
   logic         irq_clr;
   logic [W-1:0] cnt;
   logic         running;
   logic         upd_irq;
   logic         cc_irq;
   logic         cc_out;

   tim_cnt #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .clk_pre  (clk_pre),
      .en       (en),
      .one_shot (one_shot),
      .arr      (arr),
      .ccr      (ccr),
      .irq_clr  (irq_clr),
      .cnt      (cnt),
      .running  (running),
      .upd_irq  (upd_irq),
      .cc_irq   (cc_irq),
      .cc_out   (cc_out)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Timer model: mode, count, flags and last sampled prescaler level.
   int m_mode;
   int m_cnt;
   bit m_upd;
   bit m_cc;
   bit m_pre_q;

   typedef struct {
      bit en;
      bit pre;
      bit os;
      bit clr;
      int e_cnt;
      bit e_run;
      bit e_upd;
   } vec_t;

   vec_t tbl [12];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode  = M_IDLE;
      m_cnt   = 0;
      m_upd   = 1'b0;
      m_cc    = 1'b0;
      m_pre_q = 1'b0;
   endtask

   task automatic model_step();
      bit tick;
      tick    = clk_pre && !m_pre_q;
      m_pre_q = clk_pre;
      if (irq_clr) begin
         m_upd = 1'b0;
         m_cc  = 1'b0;
      end
      if (m_mode == M_IDLE) begin
         m_cnt = 0;
         if (en) m_mode = M_RUN;
      end else if (!en) begin
         m_mode = M_IDLE;
         m_cnt  = 0;
      end else if (m_mode == M_DONE) begin
         m_cnt = 0;
      end else if (tick) begin
         if (CMP && (m_cnt == int'(ccr))) m_cc = 1'b1;
         if (m_cnt >= int'(arr)) begin
            m_cnt = 0;
            m_upd = 1'b1;
            if (one_shot) m_mode = M_DONE;
         end else begin
            m_cnt = m_cnt + 1;
         end
      end
   endtask

   task automatic check_all();
      bit e_run;
      bit e_ccout;
      e_run   = (m_mode == M_RUN);
      e_ccout = CMP && e_run && (m_cnt < int'(ccr));
      chk("cnt", int'(cnt), m_cnt);
      chk("running", int'(running), int'(e_run));
      chk("upd_irq", int'(upd_irq), int'(m_upd));
      chk("cc_irq", int'(cc_irq), int'(m_cc));
      chk("cc_out", int'(cc_out), int'(e_ccout));
   endtask

   task automatic cyc();
      model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic do_tick();
      clk_pre = 1'b1;
      cyc();
      clk_pre = 1'b0;
      cyc();
   endtask

   // Called 1 time unit after a rising edge; reset lands mid-cycle.
   task automatic async_reset();
      #2;
      rst = 1'b0;
      #1;
      model_reset();
      check_all();
      #2;
      rst = 1'b1;
   endtask

   initial begin
      int k;
      rst      = 1'b0;
      clk_pre  = 1'b0;
      en       = 1'b0;
      one_shot = 1'b0;
      arr      = 8'd0;
      ccr      = 8'd0;
      irq_clr  = 1'b0;
      model_reset();
      #12;
      check_all();
      #1;
      rst = 1'b1;

      // One-shot with arr=2: count 0,1,2,0, park in DONE, restart via en.
      tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0};
      tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1, 1'b1, 1'b0};
      tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1, 1'b1, 1'b0};
      tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2, 1'b1, 1'b0};
      tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2, 1'b1, 1'b0};
      tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b1};
      tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1};
      tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b1};
      tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1};
      tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b1, 1'b0};
      tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1, 1'b1, 1'b0};
      tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0};
      arr = 8'd2;
      for (int i = 0; i < 12; i++) begin
         en       = tbl[i].en;
         clk_pre  = tbl[i].pre;
         one_shot = tbl[i].os;
         irq_clr  = tbl[i].clr;
         cyc();
         chk($sformatf("tbl%0d_cnt", i), int'(cnt), tbl[i].e_cnt);
         chk($sformatf("tbl%0d_running", i), int'(running), int'(tbl[i].e_run));
         chk($sformatf("tbl%0d_upd", i), int'(upd_irq), int'(tbl[i].e_upd));
      end
      irq_clr = 1'b0;

      // Continuous, arr=3, prescaler period 16 clocks.
      arr      = 8'd3;
      one_shot = 1'b0;
      en       = 1'b1;
      clk_pre  = 1'b0;
      cyc();
      k = 0;
      for (int p = 0; p < 5; p++) begin
         for (int c = 0; c < 16; c++) begin
            clk_pre = (c < 8);
            cyc();
            if (c == 0) begin
               k++;
               chk("period_cnt", int'(cnt), k % 4);
               chk("period_upd", int'(upd_irq), int'(k >= 4));
            end
         end
      end

      // Clear racing a set: set wins, later clear succeeds.
      irq_clr = 1'b1;
      cyc();
      chk("clr_upd", int'(upd_irq), 0);
      arr     = 8'd0;
      clk_pre = 1'b1;
      cyc();
      chk("clr_vs_set_upd", int'(upd_irq), 1);
      chk("arr0_cnt", int'(cnt), 0);
      clk_pre = 1'b0;
      cyc();
      chk("clr_late_upd", int'(upd_irq), 0);
      irq_clr = 1'b0;

      // arr drops below the current count: reload on the next tick.
      arr = 8'd9;
      for (int i = 0; i < 7; i++) do_tick();
      chk("arr_drop_pre_cnt", int'(cnt), 7);
      arr     = 8'd3;
      clk_pre = 1'b1;
      cyc();
      chk("arr_drop_cnt", int'(cnt), 0);
      chk("arr_drop_upd", int'(upd_irq), 1);
      clk_pre = 1'b0;
      cyc();

`ifdef TIM_CMP_EN
      arr     = 8'd9;
      ccr     = 8'd4;
      irq_clr = 1'b1;
      cyc();
      irq_clr = 1'b0;
      for (int i = 0; i < 10; i++) begin
         chk("pwm_cnt", int'(cnt), i);
         chk("pwm_cc_out", int'(cc_out), int'(i < 4));
         do_tick();
         chk("pwm_cc_irq", int'(cc_irq), int'(i >= 4));
      end
`endif

      // Asynchronous reset while cnt=5.
      arr = 8'd9;
      for (int i = 0; i < 5; i++) do_tick();
      chk("rst_pre_cnt", int'(cnt), 5);
      #2;
      rst = 1'b0;
      #1;
      chk("async_rst_cnt", int'(cnt), 0);
      chk("async_rst_running", int'(running), 0);
      chk("async_rst_upd", int'(upd_irq), 0);
      model_reset();
      #2;
      rst = 1'b1;
      cyc();
      chk("restart_running", int'(running), 1);

      // Randomized run against the model.
      for (int i = 0; i < 3000; i++) begin
         en = ($urandom_range(0, 15) != 0);
         if ($urandom_range(0, 2) == 0) clk_pre = ~clk_pre;
         if ($urandom_range(0, 49) == 0) arr = 8'($urandom_range(0, 7));
         if ($urandom_range(0, 49) == 0) ccr = 8'($urandom_range(0, 9));
         if ($urandom_range(0, 39) == 0) one_shot = 1'($urandom_range(0, 1));
         irq_clr = ($urandom_range(0, 11) == 0);
         cyc();
         if ($urandom_range(0, 499) == 0) async_reset();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
